// File: rtl/digit_argmax_if.sv
// Score handshake and result bundle for digit_argmax.
// The tie signal exists only when ARGMAX_TIE_FLAG_EN is defined.
interface digit_argmax_if #(
    parameter int SCORE_W = 4,
    parameter int IDX_W   = 4
);
    logic               start;
    logic               score_valid;
    logic [SCORE_W-1:0] score_in;
    logic               score_ready;
    logic               busy;
    logic               done;
    logic [IDX_W-1:0]   digit;
    logic [SCORE_W-1:0] max_score;
`ifdef ARGMAX_TIE_FLAG_EN
    logic               tie;

    modport master (
        output start, score_valid, score_in,
        input  score_ready, busy, done, digit, max_score, tie
    );
    modport slave (
        input  start, score_valid, score_in,
        output score_ready, busy, done, digit, max_score, tie
    );
`else
    modport master (
        output start, score_valid, score_in,
        input  score_ready, busy, done, digit, max_score
    );
    modport slave (
        input  start, score_valid, score_in,
        output score_ready, busy, done, digit, max_score
    );
`endif
endinterface

// File: rtl/digit_argmax.sv
// Sequential arg-max over NUM_CLASSES unsigned scores; ties keep the lower index.
// Optional macro ARGMAX_TIE_FLAG_EN adds a registered tie flag beside digit.
module digit_argmax #(
    parameter int SCORE_W     = 4,
    parameter int NUM_CLASSES = 10,
    parameter int IDX_W       = 4
) (
    input logic           clk,
    input logic           rst,
    digit_argmax_if.slave bus
);
    localparam logic [1:0]       IDLE     = 2'd0;
    localparam logic [1:0]       ACCEPT   = 2'd1;
    localparam logic [1:0]       DONE     = 2'd2;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLASSES - 1);

    logic [1:0]         state;
    logic [IDX_W-1:0]   count;
    logic [SCORE_W-1:0] max_p1;
    logic [IDX_W-1:0]   idx_p1;
    logic [SCORE_W-1:0] max_score_p2;
    logic [IDX_W-1:0]   digit_p2;

    logic               vld_p0;
    logic               take_p0;
    logic               last_p0;
    logic [SCORE_W-1:0] max_nxt;
    logic [IDX_W-1:0]   idx_nxt;

    function automatic logic beats(input logic [SCORE_W-1:0] cand,
                                   input logic [SCORE_W-1:0] cur);
        return cand > cur;
    endfunction

    // p0: accepted sample against the running maximum
    always_comb begin
        vld_p0  = (state == ACCEPT) && bus.score_valid;
        take_p0 = (count == '0) || beats(bus.score_in, max_p1);
        last_p0 = (count == LAST_IDX);
        max_nxt = take_p0 ? bus.score_in : max_p1;
        idx_nxt = take_p0 ? count : idx_p1;
    end

    // p1: control state and frame position
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            count        <= '0;
            digit_p2     <= '0;
            max_score_p2 <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state <= ACCEPT;
                        count <= '0;
                    end
                end
                ACCEPT: begin
                    if (vld_p0) begin
                        if (last_p0) begin
                            state        <= DONE;
                            count        <= '0;
                            digit_p2     <= idx_nxt;
                            max_score_p2 <= max_nxt;
                        end else begin
                            count <= count + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // p1: running maximum; cleared at frame start so no reset is needed
    always_ff @(posedge clk) begin
        if (state == IDLE && bus.start) begin
            max_p1 <= '0;
            idx_p1 <= '0;
        end else if (vld_p0) begin
            max_p1 <= max_nxt;
            idx_p1 <= idx_nxt;
        end
    end

`ifdef ARGMAX_TIE_FLAG_EN
    logic tie_seen;
    logic tie_p2;
    logic tie_nxt;

    // A new strict maximum forgets any earlier tie at the old value.
    always_comb begin
        tie_nxt = tie_seen;
        if (take_p0)
            tie_nxt = 1'b0;
        else if (bus.score_in == max_p1)
            tie_nxt = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tie_seen <= 1'b0;
            tie_p2   <= 1'b0;
        end else if (state == IDLE && bus.start) begin
            tie_seen <= 1'b0;
        end else if (vld_p0) begin
            tie_seen <= tie_nxt;
            if (last_p0)
                tie_p2 <= tie_nxt;
        end
    end

    assign bus.tie = tie_p2;
`endif

    // p2: outputs decoded from state or held result registers
    assign bus.score_ready = (state == ACCEPT);
    assign bus.busy        = (state != IDLE);
    assign bus.done        = (state == DONE);
    assign bus.digit       = digit_p2;
    assign bus.max_score   = max_score_p2;
endmodule
